// File: rtl/addsub_pkg.sv
// Shared types for the digit-serial add/subtract/compare unit.
package addsub_pkg;

  // Operation select presented with each operand pair.
  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_SLT  = 2'd2,
    OP_SLTU = 2'd3
  } op_t;

  // Control states of the serial engine.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Every op except ADD computes a - b, i.e. a + ~b + 1.
  function automatic logic op_is_sub(input op_t op);
    return (op != OP_ADD);
  endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Operand and result handshake bundle for addsub_serial.
//
// Handshake rules (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and its
// payload stable until that edge; ready may change freely and does not
// depend combinationally on valid. On the input side the payload is
// {a, b, op}; on the output side it is {result, zero, negative, overflow,
// carry}.
interface addsub_serial_if
  import addsub_pkg::*;
#(
  parameter int N = 32
);
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  op_t          op;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] result;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic         carry;

  // The arithmetic unit.
  modport slave (
    input  i_valid, a, b, op, o_ready,
    output i_ready, o_valid, result, zero, negative, overflow, carry
  );

  // Whoever issues operations and consumes results.
  modport master (
    output i_valid, a, b, op, o_ready,
    input  i_ready, o_valid, result, zero, negative, overflow, carry
  );
endinterface

// File: rtl/adder_n.sv
// Plain W-bit ripple adder that also exposes every internal carry, so the
// caller can pick out both the carry out and the carry into the top bit.
module adder_n #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic [W-1:0] c_out
);

  logic w_c;

  // Ripple the carry from bit 0 upward; c_out[i] is the carry out of bit i.
  always_comb begin
    w_c   = c_in;
    sum   = '0;
    c_out = '0;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c;
      c_out[i] = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
      w_c      = c_out[i];
    end
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract/compare unit. Works through an N-bit operand
// pair K bits per cycle, LSB digit first, with the carry held in a register
// between digits. Result and flags are registered and held until taken.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic           clk,
  input  logic           rst,
  addsub_serial_if.slave bus,
  output state_t         o_state
);

  localparam int DIGITS = N / K;
  localparam int CW     = $clog2(DIGITS) + 1;

  generate
    if ((N % K) != 0) begin : g_bad_digit
      $error("addsub_serial: N must be a multiple of K");
    end
  endgenerate

  // Control and datapath state.
  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  op_t           r_op;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sum;

  // Registered outputs.
  logic          r_i_ready;
  logic          r_o_valid;
  logic [N-1:0]  r_result;
  logic          r_zero;
  logic          r_negative;
  logic          r_overflow;
  logic          r_carry_flag;

  // Per-digit datapath.
  logic [K-1:0]  w_a_dig;
  logic [K-1:0]  w_b_dig;
  logic [K-1:0]  w_dig_sum;
  logic [K-1:0]  w_dig_cout;
  logic          w_msb_cin;
  logic          w_last;
  logic [N-1:0]  w_sum_full;
  logic          w_neg;
  logic          w_ovf;
  logic          w_cout;
  logic          w_lt;
  logic [N-1:0]  w_result;

  assign w_a_dig = r_a[r_cnt*K +: K];
  assign w_b_dig = r_b[r_cnt*K +: K];

  adder_n #(
    .W(K)
  ) u_digit_adder (
    .a    (w_a_dig),
    .b    (w_b_dig),
    .c_in (r_carry),
    .sum  (w_dig_sum),
    .c_out(w_dig_cout)
  );

  // Carry into the top bit of the digit: for a 1-bit digit that is simply
  // the registered carry coming in from the previous digit.
  generate
    if (K == 1) begin : g_msb_cin_k1
      assign w_msb_cin = r_carry;
      logic w_unused_cout;
      assign w_unused_cout = ^w_dig_cout;
    end else begin : g_msb_cin_kn
      assign w_msb_cin = w_dig_cout[K-2];
      logic w_unused_cout;
      assign w_unused_cout = ^w_dig_cout[K-2:0];
    end
  endgenerate

  assign w_last = (r_cnt == CW'(DIGITS - 1));

  // Full raw sum as it will look once the current digit is written back;
  // only consumed on the last digit when every lower digit is already in.
  always_comb begin
    w_sum_full                 = r_sum;
    w_sum_full[r_cnt*K +: K]   = w_dig_sum;
  end

  assign w_cout = w_dig_cout[K-1];
  assign w_neg  = w_sum_full[N-1];
  assign w_ovf  = w_msb_cin ^ w_cout;

  // Signed less-than from sign and overflow; unsigned less-than is a borrow.
  assign w_lt = (r_op == OP_SLT) ? (w_neg ^ w_ovf) : ~w_cout;

  // Compares return a 0/1 word; the flags still describe the raw sum.
  assign w_result = ((r_op == OP_ADD) || (r_op == OP_SUB)) ?
                    w_sum_full : {{(N-1){1'b0}}, w_lt};

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= OP_ADD;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
      r_sum        <= '0;
      r_i_ready    <= 1'b1;
      r_o_valid    <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_negative   <= 1'b0;
      r_overflow   <= 1'b0;
      r_carry_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid && r_i_ready) begin
            r_a       <= bus.a;
            r_b       <= op_is_sub(bus.op) ? ~bus.b : bus.b;
            r_op      <= bus.op;
            r_carry   <= op_is_sub(bus.op);
            r_cnt     <= '0;
            r_i_ready <= 1'b0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_sum[r_cnt*K +: K] <= w_dig_sum;
          r_carry             <= w_cout;
          r_cnt               <= r_cnt + CW'(1);
          if (w_last) begin
            r_result     <= w_result;
            r_zero       <= (w_sum_full == '0);
            r_negative   <= w_neg;
            r_overflow   <= w_ovf;
            r_carry_flag <= w_cout;
            r_o_valid    <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.o_ready) begin
            r_o_valid <= 1'b0;
            r_i_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_o_valid <= 1'b0;
          r_i_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.i_ready  = r_i_ready;
  assign bus.o_valid  = r_o_valid;
  assign bus.result   = r_result;
  assign bus.zero     = r_zero;
  assign bus.negative = r_negative;
  assign bus.overflow = r_overflow;
  assign bus.carry    = r_carry_flag;
  assign o_state      = r_state;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial (N=32, K=8): directed literal vectors plus a
// reference model fed through an expected queue and checked every cycle.
module tb_addsub_serial;
  import addsub_pkg::*;

  localparam int N = 32;
  localparam int K = 8;
  localparam int LAT = N / K;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  addsub_serial_if #(.N(N)) bus ();

  addsub_serial #(.N(N), .K(K)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .o_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [N+3:0] exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  last_accept = 0;
  int  prev_accept = 0;
  bit  rand_rdy = 0;
  bit  prev_ov  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model: {result, zero, negative, overflow, carry} from plain arithmetic.
  function automatic logic [N+3:0] model(input op_t op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0]   full;
    logic [N-1:0] s;
    logic [N-1:0] res;
    logic         c, v;
    if (op == OP_ADD) begin
      full = {1'b0, a} + {1'b0, b};
      s    = full[N-1:0];
      c    = full[N];
      v    = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    end else begin
      s = a - b;
      c = (a >= b);
      v = (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
    end
    case (op)
      OP_SLT:  res = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_SLTU: res = (a < b) ? 1 : 0;
      default: res = s;
    endcase
    return {res, (s == 0), s[N-1], v, c};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 0;
    end else begin
      if (bus.o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("result_flags", {bus.result, bus.zero, bus.negative, bus.overflow, bus.carry}, exp_q[0]);
          check("i_ready_while_valid", bus.i_ready, 0);
          if (!prev_ov) check("latency", cyc - last_accept, LAT);
          if (bus.o_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = bus.o_valid;
    end
  end

  // Random consumer back-pressure during the random phase.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.o_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input op_t op, input logic [N-1:0] a, input logic [N-1:0] b, input bit expect_res);
    int n = 0;
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    while (!bus.i_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.i_ready) begin
      check("accept_timeout", 0, 1);
      bus.i_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    prev_accept = last_accept;
    last_accept = cyc;
    if (expect_res) exp_q.push_back(model(op, a, b));
    // Scramble the inputs right after accept; the unit must ignore them.
    bus.i_valid = 1'b0;
    bus.a  = $urandom;
    bus.b  = $urandom;
    bus.op = op_t'($urandom_range(0, 3));
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!bus.o_valid && n < 50) begin @(negedge clk); n++; end
    if (!bus.o_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic run_lit(input string name, input op_t op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] lit_res, input logic [3:0] lit_flags);
    check({name, "_model"}, model(op, a, b), {lit_res, lit_flags});
    issue(op, a, b, 1);
    wait_valid();
    check({name, "_dut"}, {bus.result, bus.zero, bus.negative, bus.overflow, bus.carry}, {lit_res, lit_flags});
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] tbl[5];
    tbl[0] = 0; tbl[1] = 1; tbl[2] = 32'hFFFF_FFFF; tbl[3] = 32'h8000_0000; tbl[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 2) == 0) return tbl[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bus.i_valid = 0; bus.a = 0; bus.b = 0; bus.op = OP_ADD; bus.o_ready = 1;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i_ready", bus.i_ready, 1);
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_flags", {bus.zero, bus.negative, bus.overflow, bus.carry}, 0);
    check("rst_state", dbg_state, S_IDLE);
    @(posedge clk); #1; rst = 0;

    // Directed vectors; flags are {zero, negative, overflow, carry}.
    run_lit("add_5_3",    OP_ADD,  32'h5,         32'h3, 32'h8,         4'b0000);
    run_lit("sub_min_1",  OP_SUB,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011);
    run_lit("slt_m1_1",   OP_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1,         4'b0101);
    run_lit("sltu_m1_1",  OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0,         4'b0101);
    run_lit("sub_7_7",    OP_SUB,  32'h7,         32'h7, 32'h0,         4'b1001);

    // Wrap-around ADD while the consumer stalls for 5 cycles.
    @(posedge clk); #1; bus.o_ready = 0;
    run_lit("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", bus.o_valid, 1);
      check("hold_i_ready", bus.i_ready, 0);
      check("hold_result", {bus.result, bus.zero, bus.carry}, {32'h0, 2'b11});
    end
    @(posedge clk); #1; bus.o_ready = 1;

    // Abort mid-BUSY: no result may appear.
    issue(OP_ADD, 32'h1, 32'h2, 0);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    check("abort_i_ready", bus.i_ready, 1);
    check("abort_o_valid", bus.o_valid, 0);
    check("abort_state", dbg_state, S_IDLE);
    check("abort_result", bus.result, 0);
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      check("abort_no_valid", bus.o_valid, 0);
    end
    run_lit("after_abort", OP_ADD, 32'h1234, 32'h1111, 32'h2345, 4'b0000);

    // Back-to-back issue: accept-to-accept interval.
    for (int i = 0; i < 6; i++) begin
      issue(op_t'(i % 4), pick(), pick(), 1);
      if (i > 0) check("issue_interval", last_accept - prev_accept, LAT + 2);
    end

    // Random operations against the model with random back-pressure.
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) issue(op_t'($urandom_range(0, 3)), pick(), pick(), 1);
    rand_rdy = 0;
    @(posedge clk); #1; bus.o_ready = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
